psum_requant: RTL and testbench
===============================

PSUM_REQUANT -- requirements
Module: psum_requant

Interface
- REQ-001: Parameter NUM_COLS, default 32: psum lanes per row.
- REQ-002: Parameter PSUM_BW, default 32: signed psum width.
- REQ-003: Parameter ADDR_PSUM, default 12: psum address width.
- REQ-004: Parameter OUT_BW, default 8: signed output width.
- REQ-005: clk  in  1  sole clock, all state updates on rising edge.
- REQ-006: resetn  in  1  reset, synchronous and active-low.
- REQ-007: start  in  1  one-cycle pulse, begins a job; sampled only in IDLE.
- REQ-008: QMULT  in  16  unsigned requant multiplier; sampled at accepted start.
- REQ-009: QSHIFT  in  5  right shift amount; sampled at accepted start.
- REQ-010: QZP  in  OUT_BW  signed output zero point; sampled at accepted start.
- REQ-011: RELU_EN  in  1  ReLU enable; sampled at accepted start.
- REQ-012: NUM_VALID  in  6  active lanes per row, 1..NUM_COLS; 0 means NUM_COLS; sampled at accepted start.
- REQ-013: in_valid  in  1  psum row offered.
- REQ-014: in_ready  out  1  row accepted when in_valid and in_ready are both high.
- REQ-015: in_last  in  1  offered row is the job's final row.
- REQ-016: psum_rows  in  PSUM_BW*NUM_COLS  lane i at bits [PSUM_BW*(i+1)-1 : PSUM_BW*i].
- REQ-017: psum_addrs  in  ADDR_PSUM*NUM_COLS  lane i at bits [ADDR_PSUM*(i+1)-1 : ADDR_PSUM*i].
- REQ-018: out_valid  out  1  out_data/out_addr/out_last are valid.
- REQ-019: out_ready  in  1  consumer accepts the output.
- REQ-020: out_data  out  OUT_BW  signed requantized value.
- REQ-021: out_addr  out  ADDR_PSUM  address of the source lane.
- REQ-022: out_last  out  1  final output of the job.
- REQ-023: done  out  1  one-cycle pulse at job end.

Function
- REQ-024: FSM states: IDLE, WAIT_ROW, EMIT, FLUSH.
- REQ-025: Transitions: IDLE->WAIT_ROW on start; WAIT_ROW->EMIT on row handshake; EMIT->WAIT_ROW after the last active lane issues (non-last row); EMIT->FLUSH after the last active lane issues (last row); FLUSH->IDLE when the out_last transfer completes, with done pulsed that same cycle.
- REQ-026: in_ready is high only in WAIT_ROW. Handshake captures all lanes, addresses and in_last into holding registers.
- REQ-027: EMIT issues one lane per advancing cycle, in order 0..NUM_VALID-1. Lanes >= NUM_VALID are never emitted.
- REQ-028: Two-stage pipeline: S1 registers the product, S2 registers out_data/out_addr/out_last. Output appears on the 2nd rising edge after lane issue.
- REQ-029: The pipeline advances only when (out_ready or not out_valid). Otherwise lane counter, S1 and S2 hold, and outputs stay stable.
- REQ-030: Latency: row captured at edge E0 gives lane 0 out_valid after edge E2. With out_ready held high, lanes are output on consecutive cycles.
- REQ-031: Arithmetic per lane:
  - prod = psum (signed) x QMULT (zero-extended), full 49-bit signed.
  - If QSHIFT > 0: r = (prod + 2^(QSHIFT-1)) >>> QSHIFT (round half up). If QSHIFT = 0: r = prod.
  - y = r + QZP.
  - If RELU_EN and y < QZP: y = QZP.
  - Saturate y to [-128, 127].
- REQ-032: out_last is high only with lane NUM_VALID-1 of the row captured with in_last=1.
- REQ-033: start outside IDLE is ignored, and the configuration does not change.
- REQ-034: in_valid outside WAIT_ROW is ignored. Once offered, a row's psum_rows/psum_addrs/in_last must stay stable until the handshake (source rule).

Reset
- REQ-035: resetn low at a rising edge forces IDLE and clears the lane counter and pipeline valid bits. in_ready, out_valid, out_data, out_addr, out_last and done are all 0. Configuration registers are 0.
- REQ-036: Reset mid-job abandons the job without a done pulse. The block accepts a new start on the first edge after resetn returns high.

Verification
- REQ-037: QMULT=16384, QSHIFT=15, QZP=0, RELU off, NUM_VALID=32; lanes 100, 3, -3, 1000, -300 -> outputs 50, 2, -1, 127, -128.
- REQ-038: Same config with RELU_EN=1 and QZP=5; lane -300 -> 5, lane 100 -> 55.
- REQ-039: NUM_VALID=4, two rows with the second marked in_last, out_ready high -> exactly 8 outputs; out_last only on the 8th; done pulses once, on the cycle the 8th output transfers.
- REQ-040: out_ready low for 3 cycles mid-row -> out_data and out_addr held; no lane lost or duplicated; order preserved.
- REQ-041: start pulsed during EMIT with different QMULT -> ignored; remaining outputs use the original QMULT.
- REQ-042: resetn low during EMIT -> next cycle in_ready=0, out_valid=0, done=0; a new start followed by one row completes normally.

Source files
------------

// File: rtl/psum_requant.sv
// Psum requantizer: takes rows of NUM_COLS signed partial sums, scales each
// active lane by QMULT, applies a rounding right shift, adds the output zero
// point, optionally clamps at the zero point (ReLU) and saturates to OUT_BW.
// Lanes leave one at a time through a two-stage pipeline with valid/ready.
//
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   start                        job start pulse (honoured in IDLE only)
//   QMULT, QSHIFT, QZP, RELU_EN  requant configuration, captured at start
//   NUM_VALID                    active lanes per row (0 selects NUM_COLS)
//   in_valid/in_ready/in_last    row handshake and final-row marker
//   psum_rows, psum_addrs        packed lanes, lane i in slice i
//   out_valid/out_ready          output handshake
//   out_data, out_addr, out_last requantized lane, its address, job end marker
//   done                         one-cycle pulse when the job completes
module psum_requant #(
    parameter int unsigned NUM_COLS  = 32,
    parameter int unsigned PSUM_BW   = 32,
    parameter int unsigned ADDR_PSUM = 12,
    parameter int unsigned OUT_BW    = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic [15:0]                   QMULT,
    input  logic [4:0]                    QSHIFT,
    input  logic [OUT_BW-1:0]             QZP,
    input  logic                          RELU_EN,
    input  logic [5:0]                    NUM_VALID,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_last,
    input  logic [PSUM_BW*NUM_COLS-1:0]   psum_rows,
    input  logic [ADDR_PSUM*NUM_COLS-1:0] psum_addrs,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_BW-1:0]             out_data,
    output logic [ADDR_PSUM-1:0]          out_addr,
    output logic                          out_last,
    output logic                          done
);

    localparam int unsigned PROD_W = PSUM_BW + 17;
    localparam int unsigned Y_W    = PROD_W + 1;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned IDX_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    localparam logic signed [Y_W-1:0] SAT_MAX = (Y_W'(1) <<< (OUT_BW - 1)) - Y_W'(1);
    localparam logic signed [Y_W-1:0] SAT_MIN = -SAT_MAX - Y_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ROW = 2'd1,
        EMIT     = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    state_t state;

    // Job configuration
    logic [15:0]              cfg_qmult;
    logic [4:0]               cfg_qshift;
    logic signed [OUT_BW-1:0] cfg_qzp;
    logic                     cfg_relu;
    logic [5:0]               cfg_nvalid;

    // Captured row
    logic [PSUM_BW*NUM_COLS-1:0]   row_hold;
    logic [ADDR_PSUM*NUM_COLS-1:0] addr_hold;
    logic                          row_last;
    logic [CNT_W-1:0]              lane_cnt;

    // Stage 1: product of the issued lane
    logic                     s1_valid;
    logic signed [PROD_W-1:0] s1_prod;
    logic [ADDR_PSUM-1:0]     s1_addr;
    logic                     s1_last;

    logic                     adv_c;
    logic                     issue_c;
    logic [CNT_W-1:0]         n_eff_c;
    logic                     last_lane_c;
    logic [IDX_W-1:0]         lane_idx_c;
    logic signed [PSUM_BW-1:0] lane_psum_c;
    logic [ADDR_PSUM-1:0]     lane_addr_c;
    logic signed [16:0]       qmult_s_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] rnd_c;
    logic signed [Y_W-1:0]    y_c;
    logic [OUT_BW-1:0]        sat_c;

    // Pipeline moves whenever the output slot is free or being drained
    assign adv_c   = out_ready | ~out_valid;
    assign issue_c = (state == EMIT) && adv_c;

    // Zero (or an out-of-range count) selects the full row width
    always_comb begin
        n_eff_c = CNT_W'(cfg_nvalid);
        if (cfg_nvalid == '0 || CNT_W'(cfg_nvalid) > CNT_W'(NUM_COLS)) begin
            n_eff_c = CNT_W'(NUM_COLS);
        end
    end

    assign last_lane_c = (lane_cnt == n_eff_c - CNT_W'(1));
    assign lane_idx_c  = lane_cnt[IDX_W-1:0];

    // Lane select from the holding registers
    always_comb begin
        lane_psum_c = '0;
        lane_addr_c = '0;
        for (int i = 0; i < int'(NUM_COLS); i++) begin
            if (lane_idx_c == IDX_W'(i)) begin
                lane_psum_c = row_hold[i*PSUM_BW +: PSUM_BW];
                lane_addr_c = addr_hold[i*ADDR_PSUM +: ADDR_PSUM];
            end
        end
    end

    // QMULT is unsigned: widen with a zero MSB before the signed multiply
    assign qmult_s_c = $signed({1'b0, cfg_qmult});
    assign prod_c    = PROD_W'(lane_psum_c) * PROD_W'(qmult_s_c);

    // Round half up, add zero point, optional ReLU at the zero point, saturate
    always_comb begin
        rnd_c = s1_prod;
        if (cfg_qshift != '0) begin
            rnd_c = (s1_prod + (PROD_W'(1) <<< (cfg_qshift - 5'd1))) >>> cfg_qshift;
        end
        y_c = Y_W'(rnd_c) + Y_W'(cfg_qzp);
        if (cfg_relu && (y_c < Y_W'(cfg_qzp))) begin
            y_c = Y_W'(cfg_qzp);
        end
        if (y_c > SAT_MAX) begin
            sat_c = OUT_BW'(SAT_MAX);
        end else if (y_c < SAT_MIN) begin
            sat_c = OUT_BW'(SAT_MIN);
        end else begin
            sat_c = OUT_BW'(y_c);
        end
    end

    // Control FSM, row capture and both pipeline stages
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            cfg_qmult  <= '0;
            cfg_qshift <= '0;
            cfg_qzp    <= '0;
            cfg_relu   <= 1'b0;
            cfg_nvalid <= '0;
            row_hold   <= '0;
            addr_hold  <= '0;
            row_last   <= 1'b0;
            lane_cnt   <= '0;
            s1_valid   <= 1'b0;
            s1_prod    <= '0;
            s1_addr    <= '0;
            s1_last    <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_addr   <= '0;
            out_last   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;

            if (adv_c) begin
                out_valid <= s1_valid;
                out_last  <= s1_valid & s1_last;
                if (s1_valid) begin
                    out_data <= sat_c;
                    out_addr <= s1_addr;
                end
                s1_valid <= issue_c;
                if (issue_c) begin
                    s1_prod <= prod_c;
                    s1_addr <= lane_addr_c;
                    s1_last <= row_last & last_lane_c;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_qmult  <= QMULT;
                        cfg_qshift <= QSHIFT;
                        cfg_qzp    <= QZP;
                        cfg_relu   <= RELU_EN;
                        cfg_nvalid <= NUM_VALID;
                        in_ready   <= 1'b1;
                        state      <= WAIT_ROW;
                    end
                end
                WAIT_ROW: begin
                    if (in_valid) begin
                        row_hold  <= psum_rows;
                        addr_hold <= psum_addrs;
                        row_last  <= in_last;
                        lane_cnt  <= '0;
                        in_ready  <= 1'b0;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (adv_c) begin
                        if (last_lane_c) begin
                            lane_cnt <= '0;
                            if (row_last) begin
                                state <= FLUSH;
                            end else begin
                                in_ready <= 1'b1;
                                state    <= WAIT_ROW;
                            end
                        end else begin
                            lane_cnt <= lane_cnt + CNT_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (out_valid && out_ready && out_last) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_requant.sv
// Directed and randomized bench for psum_requant with a scoreboard queue.
module tb_psum_requant;

    localparam int NC = 32;
    localparam int PB = 32;
    localparam int AB = 12;
    localparam int OB = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [15:0]   QMULT;
    logic [4:0]    QSHIFT;
    logic [OB-1:0] QZP;
    logic          RELU_EN;
    logic [5:0]    NUM_VALID;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [PB*NC-1:0] psum_rows;
    logic [AB*NC-1:0] psum_addrs;
    logic          out_valid;
    logic          out_ready;
    logic [OB-1:0] out_data;
    logic [AB-1:0] out_addr;
    logic          out_last;
    logic          done;

    always #5 clk = ~clk;

    psum_requant #(
        .NUM_COLS (NC),
        .PSUM_BW  (PB),
        .ADDR_PSUM(AB),
        .OUT_BW   (OB)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .QMULT     (QMULT),
        .QSHIFT    (QSHIFT),
        .QZP       (QZP),
        .RELU_EN   (RELU_EN),
        .NUM_VALID (NUM_VALID),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .psum_rows (psum_rows),
        .psum_addrs(psum_addrs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .done      (done)
    );

    typedef struct packed {
        logic [OB-1:0] data;
        logic [AB-1:0] addr;
        logic          last;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_out    = 0;
    bit hold_chk = 1'b0;
    bit exp_done = 1'b0;
    bit saw_ready = 1'b0;
    bit rand_ready = 1'b0;
    logic [OB-1:0] hold_data;
    logic [AB-1:0] hold_addr;

    int cur_qm, cur_qs, cur_qz, cur_nv;
    bit cur_relu;
    int lane_val[NC];
    logic [AB-1:0] lane_adr[NC];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference requantization in 64-bit integer arithmetic
    function automatic logic [OB-1:0] model(input int psum);
        longint p, r, y;
        p = longint'(psum) * longint'(cur_qm);
        if (cur_qs == 0) r = p;
        else r = (p + (longint'(1) <<< (cur_qs - 1))) >>> cur_qs;
        y = r + longint'(cur_qz);
        if (cur_relu && y < longint'(cur_qz)) y = longint'(cur_qz);
        if (y > 127) y = 127;
        if (y < -128) y = -128;
        return OB'(y);
    endfunction

    // One clock: monitor at the falling edge, then step past the rising edge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (hold_chk) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(hold_data));
            check("stall_addr", 32'(out_addr), 32'(hold_addr));
        end
        if (done === 1'b1) n_done++;
        if (done === 1'b1 || exp_done) check("done", 32'(done), 32'(exp_done));
        exp_done  = 1'b0;
        saw_ready = (in_ready === 1'b1);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_out++;
            if (sb.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
                check("out_addr", 32'(out_addr), 32'(e.addr));
                check("out_last", 32'(out_last), 32'(e.last));
                exp_done = e.last;
            end
        end
        hold_chk  = (out_valid === 1'b1 && out_ready === 1'b0);
        hold_data = out_data;
        hold_addr = out_addr;
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_start(input int qm, input int qs, input int qz, input bit relu, input int nv);
        QMULT     = 16'(qm);
        QSHIFT    = 5'(qs);
        QZP       = OB'(qz);
        RELU_EN   = relu;
        NUM_VALID = 6'(nv);
        cur_qm = qm; cur_qs = qs; cur_qz = qz; cur_relu = relu; cur_nv = nv;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_lane(input int i, input logic [OB-1:0] d, input bit last);
        exp_t e;
        e.data = d;
        e.addr = lane_adr[i];
        e.last = last;
        sb.push_back(e);
    endtask

    // Offer the row in lane_val/lane_adr; returns just after the handshake edge
    task automatic send_row(input bit last, input bit push_exp);
        int nv;
        nv = (cur_nv == 0) ? NC : cur_nv;
        if (push_exp)
            for (int i = 0; i < nv; i++) push_lane(i, model(lane_val[i]), last && (i == nv - 1));
        for (int i = 0; i < NC; i++) begin
            psum_rows[i*PB +: PB]  = lane_val[i];
            psum_addrs[i*AB +: AB] = lane_adr[i];
        end
        in_last  = last;
        in_valid = 1'b1;
        saw_ready = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (saw_ready) break;
        end
        check("row_accept", 32'(saw_ready), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 3000; k++) begin
            if (sb.size() == 0 && out_valid !== 1'b1) break;
            tick();
        end
        check("drained", 32'(sb.size()), 32'd0);
        tick();
        tick();
    endtask

    task automatic rand_lanes(input int span);
        for (int i = 0; i < NC; i++) begin
            lane_val[i] = int'($urandom_range(0, 2 * span)) - span;
            lane_adr[i] = AB'($urandom_range(0, 4095));
        end
    endtask

    int d0, o0;

    initial begin
        resetn = 1'b0; start = 1'b0; QMULT = '0; QSHIFT = '0; QZP = '0;
        RELU_EN = 1'b0; NUM_VALID = '0; in_valid = 1'b0; in_last = 1'b0;
        psum_rows = '0; psum_addrs = '0; out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        resetn = 1'b1;

        // Reference vectors, full row selected by NUM_VALID=0
        for (int i = 0; i < NC; i++) begin
            lane_val[i] = i * 37 - 500;
            lane_adr[i] = AB'(256 + i * 5);
        end
        lane_val[0] = 100; lane_val[1] = 3; lane_val[2] = -3;
        lane_val[3] = 1000; lane_val[4] = -300;
        d0 = n_done;
        do_start(16384, 15, 0, 0, 0);
        push_lane(0, 8'd50, 1'b0);
        push_lane(1, 8'd2, 1'b0);
        push_lane(2, 8'hFF, 1'b0);
        push_lane(3, 8'd127, 1'b0);
        push_lane(4, 8'h80, 1'b0);
        for (int i = 5; i < NC; i++) push_lane(i, model(lane_val[i]), i == NC - 1);
        send_row(1'b1, 1'b0);
        drain();
        check("t1_done_count", 32'(n_done - d0), 32'd1);

        // ReLU with nonzero zero point
        lane_val[0] = -300; lane_val[1] = 100;
        do_start(16384, 15, 5, 1'b1, 2);
        push_lane(0, 8'd5, 1'b0);
        push_lane(1, 8'd55, 1'b1);
        send_row(1'b1, 1'b0);
        drain();

        // Two rows of four lanes; latency of the first lane
        d0 = n_done; o0 = n_out;
        do_start(16384, 15, 0, 0, 4);
        rand_lanes(20000);
        send_row(1'b0, 1'b1);
        check("lat_e0", 32'(out_valid), 32'd0);
        tick();
        check("lat_e1", 32'(out_valid), 32'd0);
        tick();
        check("lat_e2", 32'(out_valid), 32'd1);
        rand_lanes(20000);
        send_row(1'b1, 1'b1);
        drain();
        check("t3_out_count", 32'(n_out - o0), 32'd8);
        check("t3_done_count", 32'(n_done - d0), 32'd1);

        // Back-pressure for three cycles mid-row
        d0 = n_done;
        do_start(20000, 10, -3, 0, 6);
        rand_lanes(9000);
        send_row(1'b1, 1'b1);
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        tick();
        tick();
        out_ready = 1'b1;
        drain();
        check("t4_done_count", 32'(n_done - d0), 32'd1);

        // start during EMIT with a different configuration is ignored
        d0 = n_done;
        do_start(16384, 14, 0, 0, 8);
        rand_lanes(3000);
        send_row(1'b1, 1'b1);
        tick();
        QMULT = 16'd1; QSHIFT = 5'd0; QZP = 8'd9; NUM_VALID = 6'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        drain();
        check("t5_done_count", 32'(n_done - d0), 32'd1);

        // Reset in the middle of EMIT, then a fresh job
        do_start(16384, 15, 0, 0, 16);
        rand_lanes(5000);
        send_row(1'b1, 1'b1);
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        resetn = 1'b0;
        d0 = n_done;
        tick();
        sb.delete();
        hold_chk = 1'b0;
        exp_done = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        resetn = 1'b1;
        out_ready = 1'b1;
        do_start(12000, 12, 2, 0, 3);
        rand_lanes(4000);
        send_row(1'b1, 1'b1);
        drain();
        check("t6_done_count", 32'(n_done - d0), 32'd1);

        // Randomized configurations and random back-pressure
        rand_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            int rows;
            d0 = n_done;
            do_start(int'($urandom_range(1, 65535)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 40)) - 20, bit'($urandom_range(0, 1)),
                     int'($urandom_range(0, 32)));
            rows = int'($urandom_range(1, 3));
            for (int r = 0; r < rows; r++) begin
                rand_lanes(int'($urandom_range(100, 100000)));
                send_row(r == rows - 1, 1'b1);
            end
            rand_ready = 1'b0;
            out_ready  = 1'b1;
            drain();
            rand_ready = 1'b1;
            check("rand_done_count", 32'(n_done - d0), 32'd1);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
